voxel_ram_arbiter: RTL and testbench

- Shares one voxel block RAM read port between NUM_VTU voxel traversal units.
- Round-robin grants one read per cycle and registers address/enable to the RAM.
- Tracks in-flight reads in an in-order tag FIFO and routes each returning BlockType to the requester that issued it.
- Sits between the VTU array and the world RAM; also discards responses for VTUs that reset mid-ray.

---
 rtl/voxel_ram_arbiter_pkg.sv | 23 ++
 rtl/voxel_ram_arbiter_rr_arbiter.sv | 36 +++
 rtl/voxel_ram_arbiter.sv | 117 +++++++++++
 tb/tb_voxel_ram_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/voxel_ram_arbiter_pkg.sv
// Shared voxel types for the world-RAM read path.
//   BlockPos  : packed {x,y,z} voxel address, 4 bits per axis
//   BlockType : block id returned by the world RAM
//   VtuId     : traversal-unit index, wide enough for the largest array (8)
//   RamTag    : one in-flight read; kill marks a response nobody wants
package voxel_ram_arbiter_pkg;

  typedef logic [11:0] BlockPos;
  typedef logic [3:0]  BlockType;

  localparam BlockType BLOCK_AIR = 4'd0;

  // Sized for the maximum supported NUM_VTU so the tag format does not
  // change with the array size.
  localparam int VTU_ID_W = 3;
  typedef logic [VTU_ID_W-1:0] VtuId;

  typedef struct packed {
    VtuId id;
    logic kill;
  } RamTag;

endpackage

// File: rtl/voxel_ram_arbiter_rr_arbiter.sv
// Combinational round-robin picker.
//   req : request vector
//   ptr : highest-priority index this cycle
//   gnt : one-hot winner (zero when no request)
//   idx : winner index
//   any : at least one request present
module voxel_ram_arbiter_rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  int j;

  // Walk from ptr upward with wrap; the first hit wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/voxel_ram_arbiter.sv
// Shares one world-RAM read port between NUM_VTU traversal units.
//   clk_in, rst_n_in     : clock, async active-low reset
//   vtu_ram_addr/_enable : per-VTU read requests (held until vtu_ram_valid)
//   vtu_cancel           : per-VTU pulse dropping that VTU's in-flight read
//   vtu_ram_out/_valid   : broadcast data plus one-hot owner strobe
//   ram_addr/_read_enable: registered request to the RAM
//   ram_out/ram_valid    : in-order RAM response
module voxel_ram_arbiter
  import voxel_ram_arbiter_pkg::*;
#(
  parameter int NUM_VTU   = 4,
  parameter int TAG_DEPTH = 4
) (
  input  logic                                    clk_in,
  input  logic                                    rst_n_in,
  input  logic [NUM_VTU-1:0][$bits(BlockPos)-1:0] vtu_ram_addr,
  input  logic [NUM_VTU-1:0]                      vtu_ram_read_enable,
  input  logic [NUM_VTU-1:0]                      vtu_cancel,
  output logic [$bits(BlockType)-1:0]             vtu_ram_out,
  output logic [NUM_VTU-1:0]                      vtu_ram_valid,
  output logic [$bits(BlockPos)-1:0]              ram_addr,
  output logic                                    ram_read_enable,
  input  logic [$bits(BlockType)-1:0]             ram_out,
  input  logic                                    ram_valid
);

  localparam int IW = (NUM_VTU > 1) ? $clog2(NUM_VTU) : 1;
  localparam int PW = $clog2(TAG_DEPTH);

  logic [NUM_VTU-1:0] pending, pending_nxt, eligible, gnt_oh, head_oh;
  logic [IW-1:0]      rr_ptr, win;
  logic               any_elig, grant, pop, full, head_kill, deliver;

  RamTag              fifo [TAG_DEPTH];
  RamTag              head;
  logic [PW-1:0]      wr_ptr, rd_ptr;
  logic [PW:0]        count;

  // A cancelling VTU is not eligible this cycle, so its stale read and a
  // fresh one can never be granted on the same edge.
  assign eligible = vtu_ram_read_enable & ~pending & ~vtu_cancel;
  // Registered occupancy: a pop this cycle does not free a slot until next.
  assign full     = (count == (PW+1)'(TAG_DEPTH));
  assign grant    = any_elig & ~full;
  // ram_valid with nothing in flight is dropped.
  assign pop      = ram_valid & (count != '0);
  assign head     = fifo[rd_ptr];

  voxel_ram_arbiter_rr_arbiter #(.N(NUM_VTU), .IW(IW)) u_rr (
    .req (eligible),
    .ptr (rr_ptr),
    .gnt (gnt_oh),
    .idx (win),
    .any (any_elig)
  );

  always_comb begin
    head_oh = '0;
    for (int i = 0; i < NUM_VTU; i++) head_oh[i] = (head.id == VtuId'(i));
  end

  // A cancel arriving with the response kills it just like an earlier one.
  assign head_kill = head.kill | |(head_oh & vtu_cancel);
  assign deliver   = pop & ~head_kill;

  always_comb begin
    pending_nxt = pending & ~vtu_cancel;
    if (deliver) pending_nxt = pending_nxt & ~head_oh;
    if (grant)   pending_nxt = pending_nxt | gnt_oh;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rr_ptr          <= '0;
      ram_addr        <= '0;
      ram_read_enable <= 1'b0;
      vtu_ram_out     <= BLOCK_AIR;
      vtu_ram_valid   <= '0;
      pending         <= '0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
    end else begin
      pending         <= pending_nxt;
      ram_read_enable <= grant;
      vtu_ram_valid   <= deliver ? head_oh : '0;
      if (grant) begin
        ram_addr <= vtu_ram_addr[win];
        rr_ptr   <= (win == IW'(NUM_VTU-1)) ? '0 : win + 1'b1;
        wr_ptr   <= wr_ptr + 1'b1;
      end
      if (pop) begin
        vtu_ram_out <= ram_out;
        rd_ptr      <= rd_ptr + 1'b1;
      end
      count <= count + {{PW{1'b0}}, grant} - {{PW{1'b0}}, pop};
    end
  end

  // Tag storage has no reset: pointers define validity. Kill marks on
  // empty slots are harmless because a push rewrites the whole tag.
  always_ff @(posedge clk_in) begin
    for (int e = 0; e < TAG_DEPTH; e++)
      for (int i = 0; i < NUM_VTU; i++)
        if (vtu_cancel[i] && fifo[e].id == VtuId'(i)) fifo[e].kill <= 1'b1;
    if (grant) fifo[wr_ptr] <= '{id: VtuId'(win), kill: 1'b0};
  end

  always @(posedge clk_in) begin
    if (rst_n_in)
      assert (!(ram_valid && count == '0))
        else $warning("ram_valid received with no read in flight");
  end

  assert property (@(posedge clk_in) disable iff (!rst_n_in) $onehot0(vtu_ram_valid));

endmodule

// File: tb/tb_voxel_ram_arbiter.sv
module tb_voxel_ram_arbiter;
  import voxel_ram_arbiter_pkg::*;

  localparam int NV = 4;
  localparam int TD = 4;
  localparam int AW = $bits(BlockPos);
  localparam int BW = $bits(BlockType);

  logic                   clk;
  logic                   rst_n;
  logic [NV-1:0][AW-1:0]  vaddr;
  logic [NV-1:0]          ven, vcan, vvld;
  logic [BW-1:0]          vout, rout;
  logic [AW-1:0]          raddr;
  logic                   ren, rvld;

  voxel_ram_arbiter #(.NUM_VTU(NV), .TAG_DEPTH(TD)) dut (
    .clk_in              (clk),
    .rst_n_in            (rst_n),
    .vtu_ram_addr        (vaddr),
    .vtu_ram_read_enable (ven),
    .vtu_cancel          (vcan),
    .vtu_ram_out         (vout),
    .vtu_ram_valid       (vvld),
    .ram_addr            (raddr),
    .ram_read_enable     (ren),
    .ram_out             (rout),
    .ram_valid           (rvld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NV-1:0] oh;
    BlockType      data;
  } exp_t;

  exp_t     sb [$];
  BlockPos  aq [NV][$];
  BlockType rq [$];
  logic          stall, stray;
  logic [NV-1:0] can_req;
  int n_cmp, n_bad, n_pulse, n_deliv;
  int p0, d0;

  function automatic BlockType fdat(BlockPos a);
    return BlockType'(a[3:0] + a[11:8] + 4'd1);
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_dlv(int id, BlockPos a);
    exp_t e;
    e.oh     = '0;
    e.oh[id] = 1'b1;
    e.data   = fdat(a);
    sb.push_back(e);
  endtask

  // One clock: drive RAM and VTU models after the edge, sample at negedge.
  task automatic tick();
    exp_t e;
    @(posedge clk); #1;
    if (stray) begin
      rvld = 1'b1; rout = 4'h7; stray = 1'b0;
    end else if (!stall && rq.size() > 0) begin
      rvld = 1'b1; rout = rq.pop_front();
    end else begin
      rvld = 1'b0;
    end
    vcan = can_req;
    for (int i = 0; i < NV; i++) begin
      if ((can_req[i] || vvld[i]) && aq[i].size() > 0) void'(aq[i].pop_front());
      if (aq[i].size() > 0) begin
        ven[i]   = 1'b1;
        vaddr[i] = aq[i][0];
      end else begin
        ven[i]   = 1'b0;
      end
    end
    can_req = '0;
    @(negedge clk);
    if (ren) begin
      n_pulse++;
      rq.push_back(fdat(raddr));
    end
    if (vvld != '0) begin
      n_deliv++;
      if (sb.size() == 0) chk("sb_unexpected", 32'(vvld), 0);
      else begin
        e = sb.pop_front();
        chk("sb_vld", 32'(vvld), 32'(e.oh));
        chk("sb_data", 32'(vout), 32'(e.data));
      end
    end
  endtask

  // Called at a negedge: asserts reset mid-cycle and checks outputs at once.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ren", 32'(ren), 0);
    chk("rst_addr", 32'(raddr), 0);
    chk("rst_vld", 32'(vvld), 0);
    chk("rst_out", 32'(vout), 32'(BLOCK_AIR));
    for (int i = 0; i < NV; i++) aq[i].delete();
    rq.delete();
    ven = '0; vcan = '0; rvld = 1'b0; stall = 1'b0; can_req = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1; vaddr = '0; ven = '0; vcan = '0; rout = '0; rvld = 1'b0;
    stall = 1'b0; stray = 1'b0; can_req = '0;
    n_cmp = 0; n_bad = 0; n_pulse = 0; n_deliv = 0;
    do_reset();

    // single request, 1-cycle RAM
    aq[0].push_back(12'h123);
    expect_dlv(0, 12'h123);
    tick(); chk("t1_idle", 32'(ren), 0);
    tick(); chk("t1_ren", 32'(ren), 1); chk("t1_addr", 32'(raddr), 32'h123);
    tick(); chk("t1_novld", 32'(vvld), 0);
    tick(); chk("t1_vld", 32'(vvld), 4'b0001); chk("t1_out", 32'(vout), 5);
    repeat (3) tick();

    // round-robin fairness with re-requests
    do_reset();
    p0 = n_pulse;
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < NV; i++) begin
        BlockPos a;
        a = BlockPos'((i << 8) | (r << 4) | (i + r + 1));
        aq[i].push_back(a);
        expect_dlv(i, a);
      end
    repeat (30) tick();
    chk("t2_drained", sb.size(), 0);
    chk("t2_pulses", n_pulse - p0, 12);

    // backpressure: full FIFO blocks a cancelled VTU's re-request
    do_reset();
    stall = 1'b1;
    p0 = n_pulse;
    for (int i = 0; i < NV; i++) aq[i].push_back(BlockPos'(12'h310 + i));
    repeat (8) tick();
    chk("t3_pulses", n_pulse - p0, 4);
    aq[0].push_back(12'h4a5);
    for (int i = 1; i < NV; i++) expect_dlv(i, BlockPos'(12'h310 + i));
    expect_dlv(0, 12'h4a5);
    can_req = 4'b0001;
    tick();
    repeat (4) tick();
    chk("t3_full_hold", n_pulse - p0, 4);
    stall = 1'b0;
    tick(); chk("t3_k0", 32'(ren), 0);
    tick(); chk("t3_k1", 32'(ren), 0);
    tick(); chk("t3_k2", 32'(ren), 1); chk("t3_k2_addr", 32'(raddr), 32'h4a5);
    repeat (10) tick();
    chk("t3_drained", sb.size(), 0);
    chk("t3_total", n_pulse - p0, 5);

    // cancel while the read is in flight, then re-request
    do_reset();
    stall = 1'b1;
    aq[2].push_back(12'h521);
    aq[2].push_back(12'h567);
    expect_dlv(2, 12'h567);
    repeat (3) tick();
    can_req = 4'b0100;
    tick();
    stall = 1'b0;
    d0 = n_deliv;
    repeat (10) tick();
    chk("t4_deliv", n_deliv - d0, 1);
    chk("t4_drained", sb.size(), 0);

    // cancel in the same cycle as the response
    do_reset();
    aq[1].push_back(12'h601);
    tick(); tick();
    can_req = 4'b0010;
    tick();
    d0 = n_deliv;
    repeat (4) tick();
    chk("t5_no_deliv", n_deliv - d0, 0);
    stall = 1'b1;
    p0 = n_pulse;
    for (int i = 0; i < NV; i++) aq[i].push_back(BlockPos'(12'h700 + 17 * i));
    for (int k = 0; k < NV; k++) expect_dlv((2 + k) % NV, BlockPos'(12'h700 + 17 * ((2 + k) % NV)));
    repeat (8) tick();
    chk("t5_pulses", n_pulse - p0, 4);
    stall = 1'b0;
    repeat (12) tick();
    chk("t5_drained", sb.size(), 0);

    // async reset with reads outstanding, then a stray response
    do_reset();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) aq[i].push_back(BlockPos'(12'h8c0 + i));
    repeat (4) tick();
    chk("t6_pre_ren", 32'(ren), 1);
    do_reset();
    stray = 1'b1;
    d0 = n_deliv;
    repeat (4) tick();
    chk("t6_stray", n_deliv - d0, 0);
    chk("t6_out", 32'(vout), 32'(BLOCK_AIR));

    chk("final_sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
